regfile_sequencer: RTL
======================

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 SHALL have ports: clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports: instr, input, 16, instruction {op[15:12], dest[11:8], srcA[7:4], srcB[3:0]}.
REQ-004 SHALL have ports: instr_valid in 1 (instr offered); instr_ready out 1 (block can accept).
REQ-005 SHALL have ports: a_sel, b_sel, dest_sel out 4 each; regfile read selects and write select.
REQ-006 SHALL have ports: rf_a, rf_b in 16 each; combinational regfile read data for a_sel/b_sel.
REQ-007 SHALL have ports: wdata out 16 (regfile write data); load_en out 1 (regfile write strobe).
REQ-008 SHALL have ports: done out 1 (one-cycle completion pulse); zero, carry out 1 each (flags).

Function
REQ-009 SHALL implement FSM IDLE -> READ -> EXEC -> WRITE -> IDLE; every instruction takes exactly 4 cycles, including NOP.
REQ-010 SHALL assert instr_ready only in IDLE with rst low; accept on clk edge where instr_valid && instr_ready; latch instr; go READ.
REQ-011 SHALL ignore instr and instr_valid outside IDLE; no queuing.
REQ-012 SHALL drive a_sel=srcA, b_sel=srcB from latched instr in READ, EXEC, WRITE; 0 in IDLE.
REQ-013 SHALL capture rf_a, rf_b into operand registers at end of READ.
REQ-014 SHALL compute result in EXEC and register it at end of EXEC.
REQ-015 SHALL use op codes: 0 MOV=A; 1 ADD=A+B; 2 SUB=A-B; 3 AND; 4 OR; 5 XOR; 6 NOT=~A; 7 SHL=A<<1; 8 SHR=A>>1 logical; 9 LDI=zero-extended {srcA,srcB}; A-F NOP.
REQ-016 SHALL truncate all results to 16 bits.
REQ-017 SHALL set carry at end of EXEC: ADD = bit 16 of sum; SUB = borrow (A<B unsigned); SHL = A[15]; SHR = A[0]; all other non-NOP ops = 0.
REQ-018 SHALL set zero = (result==0) at end of EXEC for non-NOP ops.
REQ-019 SHALL leave zero and carry unchanged on NOP.
REQ-020 SHALL, in WRITE: drive dest_sel=dest and wdata=result; assert done for exactly that cycle; assert load_en for exactly that cycle iff op is non-NOP.
REQ-021 SHALL drive load_en=0, done=0, dest_sel=0, wdata=0 in all states other than WRITE.
REQ-022 SHALL derive load_en as (state==WRITE && non-NOP && !rst), so reset asserted during WRITE suppresses the regfile write at that edge.
REQ-023 SHALL read the pre-write value when dest equals srcA or srcB; the write occurs only after operands are captured.
REQ-024 SHALL produce back-to-back instructions at maximum rate of one per 4 cycles; instr_ready rises the cycle after done.

Reset
REQ-025 SHALL, on rst high at a clk edge: go to IDLE; clear latched instr, operands, result, zero, carry; abandon any in-flight instruction without a write.
REQ-026 SHALL hold instr_ready=0 while rst high.
REQ-027 SHALL hold all other outputs at 0 after reset until the next accepted instruction.

Structure
REQ-028 SHALL place op code constants, FSM state enum, and field widths (OPW=4, SELW=4, DW=16) in shared package regfile_seq_pkg.
REQ-029 SHALL isolate the ALU as combinational sub-module regfile_seq_alu with inputs op, A, B, imm8 and outputs result[15:0] and carry.

Verification
REQ-030 SHALL verify all scenarios against the team's 16x16 register file (two combinational read ports) instantiated in the bench.
REQ-031 SHALL verify: LDI 0x9_3_12 -> 4 cycles later, done=1 and load_en=1 with dest_sel=3, wdata=0x0012; R3 reads 0x0012.
REQ-032 SHALL verify: R1=0xFFFF, R2=0x0001, ADD 0x1_4_1_2 -> R4=0x0000, zero=1, carry=1.
REQ-033 SHALL verify: R1=0x0001, R2=0x0002, SUB 0x2_5_1_2 -> R5=0xFFFF, carry=1, zero=0; then NOP 0xF000 -> done=1, load_en=0, flags unchanged.
REQ-034 SHALL verify: R6=0x8001, SHL 0x7_6_6_0 -> R6=0x0002, carry=1, i.e. a self-overwrite using the old value.
REQ-035 SHALL verify: rst pulsed during WRITE of ADD to R7 (R7=0x1234 before) -> no write, R7 remains 0x1234, state IDLE, all outputs 0.
REQ-036 SHALL verify: instr_valid held high with three queued instrs -> accepts exactly one every 4 cycles; changes to instr outside IDLE have no effect.

Source files
------------

// File: rtl/regfile_seq_pkg.sv
// Shared widths, op codes and FSM state encoding for the regfile sequencer.
package regfile_seq_pkg;

  localparam int OPW  = 4;
  localparam int SELW = 4;
  localparam int DW   = 16;

  localparam logic [OPW-1:0] OP_MOV = 4'h0;
  localparam logic [OPW-1:0] OP_ADD = 4'h1;
  localparam logic [OPW-1:0] OP_SUB = 4'h2;
  localparam logic [OPW-1:0] OP_AND = 4'h3;
  localparam logic [OPW-1:0] OP_OR  = 4'h4;
  localparam logic [OPW-1:0] OP_XOR = 4'h5;
  localparam logic [OPW-1:0] OP_NOT = 4'h6;
  localparam logic [OPW-1:0] OP_SHL = 4'h7;
  localparam logic [OPW-1:0] OP_SHR = 4'h8;
  localparam logic [OPW-1:0] OP_LDI = 4'h9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  // Every code above LDI is a NOP: no write, flags untouched.
  function automatic logic is_nop(input logic [OPW-1:0] op);
    return (op > OP_LDI);
  endfunction

endpackage

// File: rtl/regfile_seq_alu.sv
// Combinational ALU: result truncated to DW bits, carry/borrow per op.
module regfile_seq_alu
  import regfile_seq_pkg::*;
(
  input  logic [OPW-1:0] op,
  input  logic [DW-1:0]  a,
  input  logic [DW-1:0]  b,
  input  logic [7:0]     imm8,
  output logic [DW-1:0]  result,
  output logic           carry
);

  logic [DW:0] w_sum;
  logic [DW:0] w_diff;

  // Widened by one bit so the top bit is carry-out / borrow.
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  // Op decode; NOP codes yield zero and are ignored upstream.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_MOV: result = a;
      OP_ADD: begin
        result = w_sum[DW-1:0];
        carry  = w_sum[DW];
      end
      OP_SUB: begin
        result = w_diff[DW-1:0];
        carry  = w_diff[DW];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[DW-2:0], 1'b0};
        carry  = a[DW-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DW-1:1]};
        carry  = a[0];
      end
      OP_LDI: result = {{(DW-8){1'b0}}, imm8};
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Four-cycle instruction sequencer driving an external register file.
//
// state   | meaning
// S_IDLE  | ready for an instruction, all selects/strobes low
// S_READ  | selects driven from latched instr, operands captured at edge
// S_EXEC  | ALU evaluates operands, result and flags captured at edge
// S_WRITE | dest/wdata driven, done pulses, load_en unless NOP or rst
module regfile_sequencer
  import regfile_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  output logic [SELW-1:0] a_sel,
  output logic [SELW-1:0] b_sel,
  output logic [SELW-1:0] dest_sel,
  input  logic [DW-1:0]   rf_a,
  input  logic [DW-1:0]   rf_b,
  output logic [DW-1:0]   wdata,
  output logic            load_en,
  output logic            done,
  output logic            zero,
  output logic            carry
);

  state_t          r_state;
  state_t          w_next_state;
  logic [15:0]     r_instr;
  logic [DW-1:0]   r_op_a;
  logic [DW-1:0]   r_op_b;
  logic [DW-1:0]   r_result;
  logic            r_zero;
  logic            r_carry;

  logic [OPW-1:0]  w_op;
  logic            w_nop;
  logic            w_accept;
  logic [DW-1:0]   w_alu_result;
  logic            w_alu_carry;

  assign w_op     = r_instr[15:12];
  assign w_nop    = is_nop(w_op);
  assign w_accept = instr_valid && instr_ready;
  assign zero     = r_zero;
  assign carry    = r_carry;

  regfile_seq_alu u_alu (
    .op     (w_op),
    .a      (r_op_a),
    .b      (r_op_b),
    .imm8   (r_instr[7:0]),
    .result (w_alu_result),
    .carry  (w_alu_carry)
  );

  // State register; reset abandons any in-flight instruction.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_next_state = r_state;
    instr_ready  = 1'b0;
    a_sel        = '0;
    b_sel        = '0;
    dest_sel     = '0;
    wdata        = '0;
    load_en      = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = !rst;
        if (w_accept) w_next_state = S_READ;
      end
      S_READ: begin
        a_sel        = r_instr[7:4];
        b_sel        = r_instr[3:0];
        w_next_state = S_EXEC;
      end
      S_EXEC: begin
        a_sel        = r_instr[7:4];
        b_sel        = r_instr[3:0];
        w_next_state = S_WRITE;
      end
      S_WRITE: begin
        a_sel        = r_instr[7:4];
        b_sel        = r_instr[3:0];
        dest_sel     = r_instr[11:8];
        wdata        = r_result;
        done         = 1'b1;
        // rst gates the strobe so a reset landing on WRITE drops the write.
        load_en      = !w_nop && !rst;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: latch instr on accept, operands after READ, result/flags after EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr  <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
    end else begin
      if (w_accept) r_instr <= instr;
      if (r_state == S_READ) begin
        r_op_a <= rf_a;
        r_op_b <= rf_b;
      end
      if (r_state == S_EXEC) begin
        r_result <= w_alu_result;
        if (!w_nop) begin
          r_zero  <= (w_alu_result == '0);
          r_carry <= w_alu_carry;
        end
      end
    end
  end

endmodule
